// File: rtl/regq_pkg.sv
// rtl/regq_pkg.sv - shared state encoding and default sizes for the Q-register serial receiver
package regq_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RECV = 2'b01;
    localparam logic [1:0] ST_PAR  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_CW    = 2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RECV = ST_RECV,
        S_PAR  = ST_PAR,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/cnt_bits.sv
// rtl/cnt_bits.sv - received-bit counter with synchronous clear, enable and terminal flag
module cnt_bits #(
    parameter int WIDTH = 3,
    parameter int CW    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/regq_receptor.sv
// rtl/regq_receptor.sv - LSB-first serial-in/parallel-out receiver with valid/ack handshake
// Optional even-parity bit after each word: define REGQ_PARITY_CHECK_EN.
module regq_receptor
    import regq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             parity_err
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              busy_q, busy_d;
    logic              cnt_clr, cnt_en, cnt_term;
`ifdef REGQ_PARITY_CHECK_EN
    logic              parity_err_q, parity_err_d;
`endif

    cnt_bits #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        busy_d       = busy_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
`ifdef REGQ_PARITY_CHECK_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RECV;
                    shreg_d = '0;
                    cnt_clr = 1'b1;
                    busy_d  = 1'b1;
`ifdef REGQ_PARITY_CHECK_EN
                    parity_err_d = 1'b0;
`endif
                end
            end
            S_RECV: begin
                if (ser_valid) begin
                    shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
                    // Last bit: the counter stays at WIDTH-1 and is cleared on the next entry.
                    if (cnt_term) begin
                        data_out_d = shreg_d;
`ifdef REGQ_PARITY_CHECK_EN
                        state_d = S_PAR;
`else
                        state_d      = S_DONE;
                        busy_d       = 1'b0;
                        data_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
`ifdef REGQ_PARITY_CHECK_EN
            S_PAR: begin
                if (ser_valid) begin
                    parity_err_d = (^data_out_q) ^ ser_in;
                    state_d      = S_DONE;
                    busy_d       = 1'b0;
                    data_valid_d = 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (data_ack) begin
                    data_valid_d = 1'b0;
                    if (start) begin
                        state_d = S_RECV;
                        shreg_d = '0;
                        cnt_clr = 1'b1;
                        busy_d  = 1'b1;
`ifdef REGQ_PARITY_CHECK_EN
                        parity_err_d = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                data_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef REGQ_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
`ifdef REGQ_PARITY_CHECK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
`ifdef REGQ_PARITY_CHECK_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_regq_receptor.sv
// tb/tb_regq_receptor.sv - directed self-checking bench for regq_receptor (WIDTH=3)
module tb_regq_receptor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ser_in;
    logic       ser_valid;
    logic       data_ack;
    logic [2:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    regq_receptor #(.WIDTH(3), .CW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends bits[0] first; gap idle cycles precede each bit. In the parity build an
    // even-parity bit follows, inverted when par_flip is set.
    task automatic send_bits(input logic [2:0] bits, input int gap, input logic par_flip);
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gap; g++) begin
                ser_valid = 1'b0;
                ser_in    = ~bits[i];
                tick();
                check("gap_busy", busy, 1'b1);
            end
            ser_valid = 1'b1;
            ser_in    = bits[i];
            tick();
            if (i < 2) begin
                check("recv_busy", busy, 1'b1);
                check("recv_valid", data_valid, 1'b0);
            end
        end
`ifdef REGQ_PARITY_CHECK_EN
        check("par_busy", busy, 1'b1);
        check("par_valid", data_valid, 1'b0);
        ser_valid = 1'b1;
        ser_in    = (^bits) ^ par_flip;
        tick();
`endif
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        check("done_busy", busy, 1'b0);
    endtask

    task automatic ack_word();
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        check("ack_valid", data_valid, 1'b0);
        check("ack_busy", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; data_ack = 1'b0;
        tick();
        tick();
        check("rst_out", data_out, 3'b000);
        check("rst_valid", data_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        reset = 1'b1;
        tick();

        // Basic word 1,0,1
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_start_busy", busy, 1'b1);
        send_bits(3'b101, 0, 1'b0);
        check("basic_out", data_out, 3'b101);
        check("basic_valid", data_valid, 1'b1);
        check("basic_perr", parity_err, 1'b0);
        ack_word();

        // Gaps, then hold without ack while ser_valid toggles
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(3'b011, 1, 1'b0);
        check("gap_out", data_out, 3'b011);
        check("gap_valid", data_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            ser_valid = 1'b1;
            ser_in    = k[0];
            tick();
            check("hold_valid", data_valid, 1'b1);
            check("hold_out", data_out, 3'b011);
        end
        ser_valid = 1'b0;
        ack_word();
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        tick();
        tick();
        ser_valid = 1'b0;
        check("idle_ser_busy", busy, 1'b0);
        check("idle_ser_out", data_out, 3'b011);
        check("idle_ser_valid", data_valid, 1'b0);

        // Back-to-back words
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(3'b110, 0, 1'b0);
        check("b2b_first_out", data_out, 3'b110);
        data_ack = 1'b1;
        start    = 1'b1;
        tick();
        data_ack = 1'b0;
        start    = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_valid", data_valid, 1'b0);
        send_bits(3'b100, 0, 1'b0);
        check("b2b_second_out", data_out, 3'b100);
        check("b2b_second_valid", data_valid, 1'b1);
        ack_word();

        // start held high through RECV must not restart the word
        start = 1'b1;
        tick();
        send_bits(3'b010, 0, 1'b0);
        check("ign_start_out", data_out, 3'b010);
        check("ign_start_valid", data_valid, 1'b1);
        tick();
        check("done_start_noack", data_valid, 1'b1);
        start = 1'b0;
        ack_word();

        // Asynchronous reset mid-word
        start = 1'b1;
        tick();
        start = 1'b0;
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        tick();
        tick();
        ser_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("amid_out", data_out, 3'b000);
        check("amid_busy", busy, 1'b0);
        check("amid_valid", data_valid, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_valid", data_valid, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(3'b001, 0, 1'b0);
        check("post_rst_out", data_out, 3'b001);
        check("post_rst_valid2", data_valid, 1'b1);
        ack_word();

`ifdef REGQ_PARITY_CHECK_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(3'b101, 0, 1'b0);
        check("par_ok_err", parity_err, 1'b0);
        check("par_ok_out", data_out, 3'b101);
        ack_word();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(3'b001, 0, 1'b1);
        check("par_bad_err", parity_err, 1'b1);
        check("par_bad_out", data_out, 3'b001);
        check("par_bad_valid", data_valid, 1'b1);
        ack_word();
        check("par_err_hold", parity_err, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("par_err_clear", parity_err, 1'b0);
`else
        check("noparity_err", parity_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
